mpmc11_strip_sequencer: RTL and testbench
=========================================

Name: mpmc11_strip_sequencer

Overview:
Parametrised successor to the mpmc10 per-port state machine: sequences one request from the port's request fifo into MIG app commands, handling multi-strip reads and writes with internal strip counters and an internal hang timer. Sits between a port's request fifo and the app_* interface of the DDR controller. It adds write-strip looping, a configurable preset delay, a timeout error pulse and a fifo pop, none of which mpmc10 provides.

Parameters:
MAX_STRIPS, 16, maximum strips per request; SW = $clog2(MAX_STRIPS) is the strip-index width.
PRESET_CYCLES, 3, cycles spent in PRESET (≥1) for upstream address/data setup.
TO_BITS, 12, timeout counter width; timeout fires at all-ones.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
calib_complete  in  1  memory calibration done
fifo_empty  in  1  request fifo empty
rd_rst_busy  in  1  request fifo reset in progress
fifo_stb  in  1  head entry valid strobe
fifo_we  in  1  head entry is a write
fifo_nstrips  in  SW  head entry strip count minus one
fifo_rd  out  1  pop request fifo (1-cycle pulse)
rdy  in  1  app_rdy
wdf_rdy  in  1  app_wdf_rdy
rd_data_valid  in  1  app_rd_data_valid
cmd_en  out  1  app_en
cmd_wr  out  1  1 = write command, 0 = read
wdf_wren  out  1  app_wdf_wren
wdf_end  out  1  app_wdf_end (every strip is one app word)
req_strip_cnt  out  SW  strips accepted so far (cmd or wdf)
resp_strip_cnt  out  SW  read strips returned so far
state  out  mpmc11_state_t  current state
busy  out  1  state != IDLE
timeout_err  out  1  1-cycle pulse on timeout abort

Behaviour:
- All flops reset asynchronously on rst=0: state=IDLE, counters=0, nstrips_q=0, is_wr=0, timer=0. Outputs are decoded from registers (Moore), so after reset every output is 0 and state=IDLE.
- IDLE: go to PRESET when !fifo_empty && !rd_rst_busy && calib_complete, else stay.
- PRESET: hold PRESET_CYCLES cycles (preset counter), then go to DECODE.
- DECODE: latch nstrips_q = fifo_nstrips and is_wr = fifo_stb & fifo_we; clear both strip counters. Next state is WR_DATA if is_wr, else RD_CMD.
- WR_DATA: wdf_wren = wdf_end = 1. A beat is accepted in any cycle with wdf_rdy=1; then req_strip_cnt++. After the beat with req_strip_cnt == nstrips_q is accepted, clear req_strip_cnt and go to WR_CMD.
- WR_CMD: cmd_en = 1, cmd_wr = 1. Accept when rdy; req_strip_cnt++. After the last strip is accepted, go to DONE.
- RD_CMD: cmd_en = 1, cmd_wr = 0. Accept when rdy; req_strip_cnt++. After the last strip is accepted, go to RD_WAIT, or straight to DONE if all responses are already in.
- Response counting: resp_strip_cnt increments on rd_data_valid in RD_CMD or RD_WAIT, so early responses during command issue are counted. rd_data_valid in any other state is ignored.
- RD_WAIT: go to DONE on the rd_data_valid that makes the response count reach nstrips_q+1. The counter saturates at nstrips_q.
- DONE: fifo_rd = 1 for 1 cycle, then go to IDLE. Earliest re-entry to PRESET is the cycle after IDLE.
- Counters are SW bits and never wrap, because a request never exceeds MAX_STRIPS.
- Timer:
  - Clears on any state change and on any accepted beat, command or response; otherwise increments while busy.
  - At all-ones with calib_complete=1: next state is IDLE, timeout_err pulses, and fifo_rd pulses to drop the offending entry.
  - With calib_complete=0 the timer holds and no timeout is taken.
- Simultaneous events: the timeout abort overrides the normal transition. A final accept and a timeout in the same cycle resolve as timeout.
- Reset mid-request: everything returns immediately to the reset values; no fifo pop occurs.
- nstrips=0 means 1 strip; nstrips = MAX_STRIPS-1 is the maximum.

Decomposition:
- mpmc11_pkg holds:
  - mpmc11_state_t enum: IDLE, PRESET, DECODE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, DONE.
  - The default localparams.
  - The strip-count typedef.
- One sub-module: mpmc11_strip_counter (SW-bit counter with clear, increment enable and terminal-match output), instantiated for the req and resp counts.

Test Plan:
- Single read: nstrips=0, rdy=1, one rd_data_valid 3 cycles after cmd → IDLE→PRESET(3)→DECODE→RD_CMD(1 cycle cmd_en)→RD_WAIT→DONE (fifo_rd pulse)→IDLE; resp_strip_cnt=0 at completion.
- 4-strip write with wdf_rdy toggling 1,0,1,0…: exactly 4 wdf_wren accepts, then 4 cmd_en/cmd_wr=1 accepts; one fifo_rd pulse; timeout_err=0.
- 8-strip read with responses arriving during RD_CMD (rdy stalls 2 cycles): all 8 counted; DONE is entered directly once the last command is accepted and all 8 responses are in.
- Hang: read with no rd_data_valid, calib_complete=1 → after 4095 idle cycles timeout_err=1 and fifo_rd=1 in the same cycle; next state=IDLE.
- calib_complete=0 with fifo non-empty → stays IDLE. Force state busy with calib_complete deasserted → no timeout after 5000 cycles.
- rst asserted low mid WR_CMD → outputs immediately 0 and state IDLE; no fifo_rd.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// Shared types and default parameters for the mpmc11 per-port strip sequencer.
package mpmc11_pkg;

  localparam int DEF_MAX_STRIPS    = 16;
  localparam int DEF_PRESET_CYCLES = 3;
  localparam int DEF_TO_BITS       = 12;
  localparam int DEF_SW            = $clog2(DEF_MAX_STRIPS);

  typedef logic [DEF_SW-1:0] strip_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    DECODE,
    WR_DATA,
    WR_CMD,
    RD_CMD,
    RD_WAIT,
    DONE
  } mpmc11_state_t;

endpackage

// File: rtl/mpmc11_strip_counter.sv
// Strip counter with synchronous clear, increment enable and a terminal-count
// match; it saturates at the terminal value so it can never wrap.
module mpmc11_strip_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_match
);

  logic [W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_count <= '0;
    else if (i_clr)            r_count <= '0;
    else if (i_inc && !o_match) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
  assign o_match = (r_count == i_term);

endmodule

// File: rtl/mpmc11_strip_sequencer.sv
// Per-port sequencer: turns one request-fifo entry into MIG app write-data,
// command and read-response handshakes, with a hang timer that drops the entry.
module mpmc11_strip_sequencer
  import mpmc11_pkg::*;
#(
  parameter  int MAX_STRIPS    = DEF_MAX_STRIPS,
  parameter  int PRESET_CYCLES = DEF_PRESET_CYCLES,
  parameter  int TO_BITS       = DEF_TO_BITS,
  localparam int SW            = $clog2(MAX_STRIPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          calib_complete,
  input  logic          fifo_empty,
  input  logic          rd_rst_busy,
  input  logic          fifo_stb,
  input  logic          fifo_we,
  input  logic [SW-1:0] fifo_nstrips,
  output logic          fifo_rd,
  input  logic          rdy,
  input  logic          wdf_rdy,
  input  logic          rd_data_valid,
  output logic          cmd_en,
  output logic          cmd_wr,
  output logic          wdf_wren,
  output logic          wdf_end,
  output logic [SW-1:0] req_strip_cnt,
  output logic [SW-1:0] resp_strip_cnt,
  output mpmc11_state_t state,
  output logic          busy,
  output logic          timeout_err
);

  localparam int PW = $clog2(PRESET_CYCLES + 1);

  mpmc11_state_t r_state;
  logic [PW-1:0]      r_preset;
  logic [TO_BITS-1:0] r_timer;
  logic [SW-1:0]      r_nstrips;
  logic               r_is_wr;
  logic               r_resp_done;
  logic               r_timeout_err;

  logic w_busy, w_wr_beat, w_cmd_acc, w_resp, w_accept, w_abort;
  logic w_req_clr, w_req_inc, w_req_match, w_resp_clr, w_resp_match, w_resp_all;

  assign w_busy    = (r_state != IDLE);
  assign w_wr_beat = (r_state == WR_DATA) && wdf_rdy;
  assign w_cmd_acc = ((r_state == WR_CMD) || (r_state == RD_CMD)) && rdy;
  assign w_resp    = ((r_state == RD_CMD) || (r_state == RD_WAIT)) && rd_data_valid;
  assign w_accept  = w_wr_beat || w_cmd_acc || w_resp;
  assign w_abort   = w_busy && calib_complete && (&r_timer);

  // The resp counter saturates at nstrips_q, so the (nstrips_q+1)-th response
  // is remembered separately in r_resp_done.
  assign w_resp_all = r_resp_done || (w_resp && w_resp_match);

  assign w_req_clr  = (r_state == DECODE) || (w_wr_beat && w_req_match);
  assign w_req_inc  = w_wr_beat || w_cmd_acc;
  assign w_resp_clr = (r_state == DECODE);

  mpmc11_strip_counter #(.W(SW)) u_req_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_req_clr),
    .i_inc   (w_req_inc),
    .i_term  (r_nstrips),
    .o_count (req_strip_cnt),
    .o_match (w_req_match)
  );

  mpmc11_strip_counter #(.W(SW)) u_resp_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_resp_clr),
    .i_inc   (w_resp),
    .i_term  (r_nstrips),
    .o_count (resp_strip_cnt),
    .o_match (w_resp_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_preset      <= '0;
      r_timer       <= '0;
      r_nstrips     <= '0;
      r_is_wr       <= 1'b0;
      r_resp_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (w_accept)                      r_timer <= '0;
      else if (w_busy && calib_complete) r_timer <= r_timer + 1'b1;

      if (r_state == DECODE)             r_resp_done <= 1'b0;
      else if (w_resp && w_resp_match)   r_resp_done <= 1'b1;

      // NOTE: a later non-blocking assignment in the same block wins, so each
      // transition below overrides the default timer update with a clear.
      if (w_abort) begin
        r_state       <= IDLE;
        r_preset      <= '0;
        r_timer       <= '0;
        r_timeout_err <= 1'b1;
      end else begin
        case (r_state)
          IDLE: if (!fifo_empty && !rd_rst_busy && calib_complete) begin
            r_state <= PRESET;
            r_timer <= '0;
          end
          PRESET: if (r_preset == PW'(PRESET_CYCLES - 1)) begin
            r_preset <= '0;
            r_state  <= DECODE;
            r_timer  <= '0;
          end else begin
            r_preset <= r_preset + 1'b1;
          end
          DECODE: begin
            r_nstrips <= fifo_nstrips;
            r_is_wr   <= fifo_stb && fifo_we;
            r_state   <= (fifo_stb && fifo_we) ? WR_DATA : RD_CMD;
            r_timer   <= '0;
          end
          WR_DATA: if (w_wr_beat && w_req_match) begin
            r_state <= WR_CMD;
            r_timer <= '0;
          end
          WR_CMD: if (w_cmd_acc && w_req_match) begin
            r_state <= DONE;
            r_timer <= '0;
          end
          RD_CMD: if (w_cmd_acc && w_req_match) begin
            r_state <= w_resp_all ? DONE : RD_WAIT;
            r_timer <= '0;
          end
          RD_WAIT: if (w_resp_all) begin
            r_state <= DONE;
            r_timer <= '0;
          end
          DONE: begin
            r_state <= IDLE;
            r_timer <= '0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign state       = r_state;
  assign busy        = w_busy;
  assign cmd_en      = (r_state == WR_CMD) || (r_state == RD_CMD);
  assign cmd_wr      = (r_state == WR_CMD) && r_is_wr;
  assign wdf_wren    = (r_state == WR_DATA);
  assign wdf_end     = (r_state == WR_DATA);
  assign fifo_rd     = (r_state == DONE) || r_timeout_err;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mpmc11_strip_sequencer.sv
// Bench for mpmc11_strip_sequencer: directed scenarios plus randomized requests
// scored by handshake counts and completion timing derived from the request.
module tb_mpmc11_strip_sequencer;
  import mpmc11_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib_complete, fifo_empty, rd_rst_busy, fifo_stb, fifo_we;
  strip_cnt_t    fifo_nstrips;
  logic          fifo_rd, rdy, wdf_rdy, rd_data_valid;
  logic          cmd_en, cmd_wr, wdf_wren, wdf_end, busy, timeout_err;
  strip_cnt_t    req_strip_cnt, resp_strip_cnt;
  mpmc11_state_t state;

  int n_cmp = 0;
  int n_bad = 0;

  mpmc11_strip_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .calib_complete (calib_complete),
    .fifo_empty     (fifo_empty),
    .rd_rst_busy    (rd_rst_busy),
    .fifo_stb       (fifo_stb),
    .fifo_we        (fifo_we),
    .fifo_nstrips   (fifo_nstrips),
    .fifo_rd        (fifo_rd),
    .rdy            (rdy),
    .wdf_rdy        (wdf_rdy),
    .rd_data_valid  (rd_data_valid),
    .cmd_en         (cmd_en),
    .cmd_wr         (cmd_wr),
    .wdf_wren       (wdf_wren),
    .wdf_end        (wdf_end),
    .req_strip_cnt  (req_strip_cnt),
    .resp_strip_cnt (resp_strip_cnt),
    .state          (state),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {cmd_en, cmd_wr, wdf_wren, wdf_end, fifo_rd, busy, timeout_err,
                           req_strip_cnt, resp_strip_cnt}, 0);
    check({tag, "_state"}, state, IDLE);
  endtask

  task automatic wait_state(input mpmc11_state_t s, input int budget, input string tag);
    int k = 0;
    while (state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, state, s);
  endtask

  // One request end to end. mode 0: always ready, 1: ready toggles 1,0,1,0..,
  // 2: random stalls. Reads return responses only for commands already issued.
  task automatic do_req(input int n, input bit we, input int mode, input string tag);
    int nbeat = 0, ncmd = 0, nwr = 0, nresp = 0, owed = 0, nfrd = 0, nto = 0;
    int npre = 0, t_fin = -1, t_rd = -1, cyc = 0;
    bit order_ok = 1'b1, tog = 1'b0;
    fifo_nstrips = strip_cnt_t'(n);
    fifo_we      = we;
    fifo_stb     = 1'b1;
    fifo_empty   = 1'b0;
    while (t_rd < 0 && cyc < 3000) begin
      @(posedge clk);
      #1;
      case (mode)
        0: begin rdy = 1'b1; wdf_rdy = 1'b1; end
        1: begin tog = !tog; rdy = tog; wdf_rdy = tog; end
        default: begin rdy = 1'($urandom_range(0, 1)); wdf_rdy = 1'($urandom_range(0, 1)); end
      endcase
      rd_data_valid = (owed > 0) && (mode == 0 || $urandom_range(0, 1) == 1);
      @(negedge clk);
      cyc++;
      if (state != IDLE) fifo_empty = 1'b1;
      if (state == PRESET) npre++;
      if (wdf_wren && wdf_rdy) begin
        nbeat++;
        if (ncmd > 0) order_ok = 1'b0;
      end
      if (cmd_en && rdy) begin
        ncmd++;
        if (cmd_wr) nwr++;
        if (!we) owed++;
      end
      if (rd_data_valid) begin
        nresp++;
        owed--;
      end
      if (fifo_rd) begin
        nfrd++;
        t_rd = cyc;
      end
      if (timeout_err) nto++;
      if (t_fin < 0 && ncmd == n + 1 && (we || nresp == n + 1)) t_fin = cyc;
    end
    check({tag, "_beats"}, nbeat, we ? n + 1 : 0);
    check({tag, "_cmds"}, ncmd, n + 1);
    check({tag, "_cmd_wr"}, nwr, we ? n + 1 : 0);
    check({tag, "_data_before_cmd"}, order_ok, 1);
    check({tag, "_preset_len"}, npre, DEF_PRESET_CYCLES);
    check({tag, "_done_cycle"}, t_rd, t_fin + 1);
    check({tag, "_fifo_rd"}, nfrd, 1);
    check({tag, "_timeout"}, nto, 0);
    check({tag, "_resp_cnt"}, resp_strip_cnt, we ? 0 : n);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    wdf_rdy = 1'b0;
    rd_data_valid = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, {fifo_rd, state}, {1'b0, IDLE});
  endtask

  initial begin
    int cnt, nto, nbad_state, nfrd;
    rst = 1'b0;
    calib_complete = 1'b1;
    fifo_empty = 1'b1;
    rd_rst_busy = 1'b0;
    fifo_stb = 1'b0;
    fifo_we = 1'b0;
    fifo_nstrips = '0;
    rdy = 1'b0;
    wdf_rdy = 1'b0;
    rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Entry gating: no calibration, then fifo still resetting.
    fifo_empty = 1'b0;
    calib_complete = 1'b0;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy) cnt++; end
    check("no_calib_idle", cnt, 0);
    calib_complete = 1'b1;
    rd_rst_busy = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (busy) cnt++; end
    check("rd_rst_busy_idle", cnt, 0);
    fifo_empty = 1'b1;
    rd_rst_busy = 1'b0;
    @(negedge clk);

    do_req(0, 1'b0, 0, "rd1");
    do_req(3, 1'b1, 1, "wr4_toggle");
    do_req(15, 1'b1, 2, "wr16");
    do_req(15, 1'b0, 2, "rd16");

    // 8-strip read: all responses arrive during command issue.
    fifo_nstrips = strip_cnt_t'(7);
    fifo_we = 1'b0;
    fifo_empty = 1'b0;
    wait_state(RD_CMD, 50, "rd8_enter");
    fifo_empty = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      rdy = (i >= 2);
      rd_data_valid = (i < 8);
      if (i == 9) check("rd8_all_resp_in_cmd", {state, resp_strip_cnt}, {RD_CMD, 4'd7});
      @(negedge clk);
      if (state == RD_WAIT) cnt++;
    end
    rdy = 1'b0;
    rd_data_valid = 1'b0;
    check("rd8_direct_done", {state, fifo_rd}, {DONE, 1'b1});
    check("rd8_no_rd_wait", cnt, 0);
    @(negedge clk);
    check("rd8_idle", {state, fifo_rd}, {IDLE, 1'b0});

    // Hang: read that never gets its response.
    fifo_nstrips = strip_cnt_t'(2);
    fifo_empty = 1'b0;
    rdy = 1'b1;
    wait_state(RD_WAIT, 100, "hang_enter");
    rdy = 1'b0;
    fifo_empty = 1'b1;
    cnt = 0;
    while (!timeout_err && cnt < 5000) begin
      if (state == RD_WAIT) cnt++;
      @(negedge clk);
    end
    check("hang_wait_cycles", cnt, 1 << DEF_TO_BITS);
    check("hang_abort", {timeout_err, fifo_rd, state}, {1'b1, 1'b1, IDLE});
    @(negedge clk);
    check("hang_pulse_end", {timeout_err, fifo_rd, state}, {1'b0, 1'b0, IDLE});

    // Busy with calibration lost: timer must hold.
    fifo_nstrips = strip_cnt_t'(0);
    fifo_empty = 1'b0;
    rdy = 1'b1;
    wait_state(RD_WAIT, 100, "nocal_enter");
    rdy = 1'b0;
    fifo_empty = 1'b1;
    calib_complete = 1'b0;
    nto = 0;
    nbad_state = 0;
    repeat (5000) begin
      @(negedge clk);
      if (timeout_err || fifo_rd) nto++;
      if (state != RD_WAIT) nbad_state++;
    end
    check("nocal_no_timeout", nto, 0);
    check("nocal_held_state", nbad_state, 0);
    rst = 1'b0;
    #1 check_all_zero("nocal_reset");
    calib_complete = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;

    // Reset asserted mid WR_CMD.
    fifo_nstrips = strip_cnt_t'(3);
    fifo_we = 1'b1;
    fifo_empty = 1'b0;
    wdf_rdy = 1'b1;
    rdy = 1'b0;
    wait_state(WR_CMD, 100, "rst_wr_enter");
    fifo_empty = 1'b1;
    wdf_rdy = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid_wr");
    nfrd = 0;
    repeat (5) begin @(negedge clk); if (fifo_rd || busy) nfrd++; end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) begin @(negedge clk); if (fifo_rd || busy) nfrd++; end
    check("rst_no_fifo_rd", nfrd, 0);

    for (int r = 0; r < 12; r++)
      do_req(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2, $sformatf("rand%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
